rom_seq_player: RTL and testbench

- Sequencer stage upstream of the 8-bit servo-pattern ROM (rom_8xM).
- Drives the ROM address and consumes the ROM data output.
- Steps through M entries at a fixed step period and presents each entry as a held position sample with a one-cycle valid strobe, for the servo PWM stage.
- Supports start/stop and one-shot or looped playback of a stored gait.

---
 rtl/rom_seq_player.sv | 171 +++++++++++++++++
 tb/tb_rom_seq_player.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_seq_player.sv
// rom_seq_player: walks the servo-pattern ROM through M entries, one entry every DIV clocks,
// presenting each as a held pos sample with a pos_valid strobe. Optional: ROM_SEQ_PINGPONG_EN.
module rom_seq_player #(
  parameter int M   = 64,
  parameter int DIV = 240000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [7:0] rom_data,
  output logic [7:0] adress,
  output logic [7:0] pos,
  output logic       pos_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int             TW     = $clog2(DIV);
  localparam logic [7:0]     LAST   = 8'(M - 1);
  localparam logic [TW-1:0]  RELOAD = TW'(DIV - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // pos_valid and done are single-cycle strobes with no backpressure: the PWM stage must
  // take pos in the cycle pos_valid is high; pos itself stays valid until the next strobe.
  state_t          state_q, state_d;
  logic [7:0]      adress_q, adress_d;
  logic [7:0]      pos_q, pos_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pos_valid_q, pos_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            end_play;
`ifdef ROM_SEQ_PINGPONG_EN
  logic            dir_down_q, dir_down_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      adress_q    <= '0;
      pos_q       <= '0;
      timer_q     <= '0;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ROM_SEQ_PINGPONG_EN
      dir_down_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      adress_q    <= adress_d;
      pos_q       <= pos_d;
      timer_q     <= timer_d;
      pos_valid_q <= pos_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ROM_SEQ_PINGPONG_EN
      dir_down_q  <= dir_down_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    adress_d    = adress_q;
    pos_d       = pos_q;
    timer_d     = timer_q;
    pos_valid_d = 1'b0;
    done_d      = 1'b0;
    end_play    = 1'b0;
`ifdef ROM_SEQ_PINGPONG_EN
    dir_down_d  = dir_down_q;
`endif
    case (state_q)
      S_IDLE: begin
        adress_d = '0;
        if (start && !stop) begin
          state_d = S_FETCH;
        end
      end
      // The ROM latches adress on the falling edge inside this cycle.
      S_FETCH: begin
        if (stop) begin
          state_d  = S_IDLE;
          adress_d = '0;
`ifdef ROM_SEQ_PINGPONG_EN
          dir_down_d = 1'b0;
`endif
        end else begin
          pos_d       = rom_data;
          pos_valid_d = 1'b1;
          timer_d     = RELOAD;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d  = S_IDLE;
          adress_d = '0;
`ifdef ROM_SEQ_PINGPONG_EN
          dir_down_d = 1'b0;
`endif
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = S_FETCH;
`ifdef ROM_SEQ_PINGPONG_EN
          if (!dir_down_q) begin
            if (adress_q != LAST) begin
              adress_d = adress_q + 8'd1;
            end else if (!loop) begin
              end_play = 1'b1;
            end else if (M == 1) begin
              adress_d = '0;
            end else begin
              dir_down_d = 1'b1;
              adress_d   = LAST - 8'd1;
            end
          end else begin
            if (adress_q != '0) begin
              adress_d = adress_q - 8'd1;
            end else if (!loop) begin
              end_play = 1'b1;
            end else begin
              dir_down_d = 1'b0;
              adress_d   = 8'd1;
            end
          end
`else
          if (adress_q != LAST) begin
            adress_d = adress_q + 8'd1;
          end else if (loop) begin
            adress_d = '0;
          end else begin
            end_play = 1'b1;
          end
`endif
          if (end_play) begin
            state_d  = S_IDLE;
            adress_d = '0;
            done_d   = 1'b1;
`ifdef ROM_SEQ_PINGPONG_EN
            dir_down_d = 1'b0;
`endif
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        adress_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign adress    = adress_q;
  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rom_seq_player.sv
// tb_rom_seq_player: event scoreboard for rom_seq_player (M=4, DIV=4) with a small ROM model
// and a step-level playback reference; honours ROM_SEQ_PINGPONG_EN when defined.
module tb_rom_seq_player;
  localparam int M   = 4;
  localparam int DIV = 4;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       loop;
  logic [7:0] rom_data;
  logic [7:0] adress;
  logic [7:0] pos;
  logic       pos_valid;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  logic [7:0]  rom_mem [M];
  logic [40:0] exp_q [$];   // {is_done, cycle[31:0], pos[7:0]}
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // playback reference: idle/playing, current entry, cycle of next pos_valid
  bit          play = 0;
  int          idx = 0;
  int          next_pv = 0;
`ifdef ROM_SEQ_PINGPONG_EN
  bit          dir_down = 0;
`endif

  rom_seq_player #(.M(M), .DIV(DIV)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .rom_data  (rom_data),
    .adress    (adress),
    .pos       (pos),
    .pos_valid (pos_valid),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset / ROM
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rom_data <= rom_mem[int'(adress) % M];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_idle();
    play = 0;
`ifdef ROM_SEQ_PINGPONG_EN
    dir_down = 0;
`endif
  endtask

  task automatic model_step(input int n, input logic s, input logic p, input logic l);
    bit end_run;
    if (!play) begin
      if (s && !p) begin
        play = 1; idx = 0; next_pv = n + 2;
      end
    end else if (p) begin
      model_idle();
    end else if (n == next_pv - 1) begin
      exp_q.push_back({1'b0, 32'(next_pv), rom_mem[idx]});
    end else if (n == next_pv + DIV - 2) begin
      end_run = 0;
`ifdef ROM_SEQ_PINGPONG_EN
      if (!dir_down) begin
        if (idx < M - 1) idx++;
        else if (!l) end_run = 1;
        else if (M > 1) begin dir_down = 1; idx = M - 2; end
      end else begin
        if (idx > 0) idx--;
        else if (!l) end_run = 1;
        else begin dir_down = 0; idx = 1; end
      end
`else
      if (idx < M - 1) idx++;
      else if (!l) end_run = 1;
      else idx = 0;
`endif
      if (end_run) begin
        model_idle();
        exp_q.push_back({1'b1, 32'(n + 1), 8'h00});
      end else begin
        next_pv += DIV;
      end
    end
  endtask

  // driver: one call = one cycle of inputs, checked against the reference's idle/busy view
  task automatic cyc_drive(input logic s, input logic p, input logic l);
    @(negedge clk);
    chk("busy", busy, play);
    chk("adress_range", adress <= 8'(M - 1), 1);
    start = s; stop = p; loop = l;
    model_step(cyc, s, p, l);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_adress"}, adress, 0);
    chk({tag, "_pos"}, pos, 0);
    chk({tag, "_pos_valid"}, pos_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rstn = 1'b0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    exp_q.delete();
    model_idle();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // scoreboard monitor
  task automatic check_event(input logic is_done);
    logic [40:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d expected none", is_done ? "done" : "pos_valid", cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", is_done, e[40]);
      chk("event_cycle", cyc, e[39:8]);
      if (!is_done) chk("pv_pos", pos, e[7:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (pos_valid) check_event(1'b0);
      if (done) check_event(1'b1);
    end
  end

  initial begin
    logic s, p, l;
    for (int i = 0; i < M; i++) rom_mem[i] = 8'(10 * (i + 1));
    rstn = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("por");
    rstn = 1'b1;
    repeat (2) cyc_drive(0, 0, 0);

    // one-shot playback
    cyc_drive(1, 0, 0);
    repeat (19) cyc_drive(0, 0, 0);
    chk("oneshot_pos_hold", pos, 40);
    chk("oneshot_adress", adress, 0);

    // looped playback, stop in cycle 8
    cyc_drive(1, 0, 1);
    repeat (7) cyc_drive(0, 0, 1);
    cyc_drive(0, 1, 1);
    cyc_drive(0, 0, 0);
    chk("stop_adress", adress, 0);
    chk("stop_pos_hold", pos, 20);
    repeat (8) cyc_drive(0, 0, 0);

    // start and stop together in idle
    cyc_drive(1, 1, 0);
    repeat (3) cyc_drive(0, 0, 0);

    // start re-pulsed while busy
    cyc_drive(1, 0, 0);
    repeat (5) cyc_drive(0, 0, 0);
    cyc_drive(1, 0, 0);
    repeat (4) cyc_drive(0, 0, 0);
    cyc_drive(1, 0, 0);
    repeat (12) cyc_drive(0, 0, 0);

    // start held high, one-shot: back-to-back replays
    repeat (40) cyc_drive(1, 0, 0);
    repeat (20) cyc_drive(0, 0, 0);

    // reset in the middle of HOLD, then replay
    cyc_drive(1, 0, 0);
    repeat (4) cyc_drive(0, 0, 0);
    mid_reset();
    cyc_drive(1, 0, 0);
    repeat (20) cyc_drive(0, 0, 0);
    chk("replay_pos_hold", pos, 40);

    // long looped run (wrap or bounce), then stop
    cyc_drive(1, 0, 1);
    repeat (40) cyc_drive(0, 0, 1);
    cyc_drive(0, 1, 1);
    repeat (3) cyc_drive(0, 0, 0);

    // randomized phase with fresh ROM contents
    for (int i = 0; i < M; i++) rom_mem[i] = 8'($urandom_range(0, 255));
    l = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) l = ~l;
      cyc_drive(s, p, l);
    end
    repeat (3 * M * DIV + 10) cyc_drive(0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
